// File: rtl/pipe_stage_hs_pkg.sv
// Shared types for the handshaked pipeline-stage register.
package pipe_stage_hs_pkg;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } hs_state_e;

  // Width of one slot entry: payload, exception vector, pc and delay-slot flag.
  function automatic int unsigned slot_width(input int unsigned payload_w,
                                             input int unsigned exc_w,
                                             input int unsigned addr_w);
    return payload_w + exc_w + addr_w + 1;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage slot: a valid bit plus a data word, with load and clear.
module pipe_slot #(
  parameter int unsigned         DataW   = 1,
  parameter logic [DataW-1:0]    NopData = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic [DataW-1:0] data_i,
  output logic             valid_o,
  output logic [DataW-1:0] data_o
);

  logic             valid_q;
  logic [DataW-1:0] data_q;

  // Clear wins so an empty slot never exposes stale data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= NopData;
    end else if (clear_i) begin
      valid_q <= 1'b0;
      data_q  <= NopData;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// Handshaked pipeline-stage register with a skid slot, flush and a saturating stall counter.
module pipe_stage_hs
  import pipe_stage_hs_pkg::*;
#(
  parameter int unsigned          PAYLOAD_W   = 72,
  parameter int unsigned          EXC_W       = 32,
  parameter int unsigned          ADDR_W      = 32,
  parameter logic [PAYLOAD_W-1:0] NOP_PAYLOAD = '0,
  parameter int unsigned          CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [PAYLOAD_W-1:0] in_payload_i,
  input  logic [EXC_W-1:0]     in_exc_i,
  input  logic [ADDR_W-1:0]    in_pc_i,
  input  logic                 in_dslot_i,
  input  logic                 next_dslot_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [PAYLOAD_W-1:0] out_payload_o,
  output logic [EXC_W-1:0]     out_exc_o,
  output logic [ADDR_W-1:0]    out_pc_o,
  output logic                 out_dslot_o,
  output logic                 is_in_dslot_o,
  output logic [CNT_W-1:0]     stall_cnt_o
);

  localparam int unsigned SlotW = slot_width(PAYLOAD_W, EXC_W, ADDR_W);
  localparam logic [SlotW-1:0] SlotNop = {NOP_PAYLOAD, {(EXC_W + ADDR_W + 1){1'b0}}};
  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [CNT_W-1:0] CntOne  = {{(CNT_W - 1){1'b0}}, 1'b1};

  hs_state_e        state_q, state_d;
  logic             ready_q;
  logic             dslot_q;
  logic [CNT_W-1:0] cnt_q;

  logic             acc, dep;
  logic             m_load, m_clear, m_from_skid, s_load, s_clear;
  logic             m_valid, s_valid;
  logic [SlotW-1:0] in_data, m_in, m_data, s_data;

  assign in_data = {in_payload_i, in_exc_i, in_pc_i, in_dslot_i};
  assign m_in    = m_from_skid ? s_data : in_data;
  assign acc     = in_valid_i & ready_q;
  assign dep     = m_valid & out_ready_i;

  always_comb begin
    state_d     = state_q;
    m_load      = 1'b0;
    m_clear     = 1'b0;
    m_from_skid = 1'b0;
    s_load      = 1'b0;
    s_clear     = 1'b0;
    if (flush_i) begin
      state_d = StEmpty;
      m_clear = 1'b1;
      s_clear = 1'b1;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (acc) begin
            m_load  = 1'b1;
            state_d = StOne;
          end
        end
        StOne: begin
          if (acc && dep) begin
            m_load = 1'b1;
          end else if (acc) begin
            s_load  = 1'b1;
            state_d = StTwo;
          end else if (dep) begin
            m_clear = 1'b1;
            state_d = StEmpty;
          end
        end
        StTwo: begin
          // Upstream is held off (ready low), so only a departure can happen here.
          if (dep) begin
            m_load      = 1'b1;
            m_from_skid = 1'b1;
            s_clear     = 1'b1;
            state_d     = StOne;
          end
        end
        default: begin
          state_d = StEmpty;
          m_clear = 1'b1;
          s_clear = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StEmpty;
      ready_q <= 1'b1;
      dslot_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != StTwo);
      if (flush_i) begin
        dslot_q <= 1'b0;
      end else if (acc) begin
        dslot_q <= next_dslot_i;
      end
      // Counts regardless of flush; only reset clears it.
      if (m_valid && !out_ready_i && (cnt_q != CntMax)) begin
        cnt_q <= cnt_q + CntOne;
      end
    end
  end

  pipe_slot #(
    .DataW   (SlotW),
    .NopData (SlotNop)
  ) u_main (
    .clk     (clk),
    .rst     (rst),
    .load_i  (m_load),
    .clear_i (m_clear),
    .data_i  (m_in),
    .valid_o (m_valid),
    .data_o  (m_data)
  );

  pipe_slot #(
    .DataW   (SlotW),
    .NopData (SlotNop)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (s_load),
    .clear_i (s_clear),
    .data_i  (in_data),
    .valid_o (s_valid),
    .data_o  (s_data)
  );

  assign in_ready_o    = ready_q;
  assign out_valid_o   = m_valid;
  assign {out_payload_o, out_exc_o, out_pc_o, out_dslot_o} = m_data;
  assign is_in_dslot_o = dslot_q;
  assign stall_cnt_o   = cnt_q;

  logic unused_s_valid;
  assign unused_s_valid = s_valid;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed self-checking bench for pipe_stage_hs (stall counter narrowed to 4 bits).
module tb_pipe_stage_hs;

  localparam int unsigned PW = 72;
  localparam int unsigned EW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush_i = 1'b0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [PW-1:0] in_payload_i = '0;
  logic [EW-1:0] in_exc_i = '0;
  logic [AW-1:0] in_pc_i = '0;
  logic          in_dslot_i = 1'b0;
  logic          next_dslot_i = 1'b0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b1;
  logic [PW-1:0] out_payload_o;
  logic [EW-1:0] out_exc_o;
  logic [AW-1:0] out_pc_o;
  logic          out_dslot_o;
  logic          is_in_dslot_o;
  logic [CW-1:0] stall_cnt_o;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  pipe_stage_hs #(
    .CNT_W (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flush_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .in_payload_i  (in_payload_i),
    .in_exc_i      (in_exc_i),
    .in_pc_i       (in_pc_i),
    .in_dslot_i    (in_dslot_i),
    .next_dslot_i  (next_dslot_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_payload_o (out_payload_o),
    .out_exc_o     (out_exc_o),
    .out_pc_o      (out_pc_o),
    .out_dslot_o   (out_dslot_o),
    .is_in_dslot_o (is_in_dslot_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  function automatic logic [PW-1:0] word(input int i);
    logic [7:0] b;
    b = i[7:0];
    return {8'hA0 + b, 64'h0123_4567_89AB_CDEF ^ {8{b}}};
  endfunction

  function automatic logic [AW-1:0] pc_of(input int i);
    return 32'h0000_1000 + 32'(i * 4);
  endfunction

  function automatic logic [EW-1:0] exc_of(input int i);
    return 32'h1 << i;
  endfunction

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input int i);
    in_valid_i   = 1'b1;
    in_payload_i = word(i);
    in_exc_i     = exc_of(i);
    in_pc_i      = pc_of(i);
    in_dslot_i   = i[0];
    next_dslot_i = i[1];
  endtask

  task automatic idle();
    in_valid_i   = 1'b0;
    in_payload_i = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_valid", PW'(out_valid_o), 0);
    chk("rst_ready", PW'(in_ready_o), 1);
    chk("rst_payload", out_payload_o, '0);
    chk("rst_cnt", PW'(stall_cnt_o), 0);
    rst = 1'b1;
    tick();

    // 1: streaming with 1-cycle latency, ready never drops
    out_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drv(i);
      tick();
      chk("s1_valid", PW'(out_valid_o), 1);
      chk("s1_payload", out_payload_o, word(i));
      chk("s1_pc", PW'(out_pc_o), PW'(pc_of(i)));
      chk("s1_exc", PW'(out_exc_o), PW'(exc_of(i)));
      chk("s1_dslot", PW'(out_dslot_o), PW'(i % 2));
      chk("s1_ready", PW'(in_ready_o), 1);
    end
    chk("s1_isdslot", PW'(is_in_dslot_o), 1);  // word 7 had next_dslot=1
    idle();
    tick();
    chk("s1_drain_valid", PW'(out_valid_o), 0);
    chk("s1_drain_payload", out_payload_o, '0);
    chk("s1_drain_pc", PW'(out_pc_o), 0);

    // 2: back-pressure, skid fill, ordered release
    out_ready_i = 1'b0;
    drv(10);
    tick();
    chk("s2_a_out", out_payload_o, word(10));
    chk("s2_a_ready", PW'(in_ready_o), 1);
    drv(11);
    tick();
    chk("s2_b_out", out_payload_o, word(10));
    chk("s2_b_ready", PW'(in_ready_o), 0);
    chk("s2_cnt1", PW'(stall_cnt_o), 1);
    drv(12);
    tick();
    tick();
    chk("s2_hold_out", out_payload_o, word(10));
    chk("s2_hold_ready", PW'(in_ready_o), 0);
    chk("s2_cnt3", PW'(stall_cnt_o), 3);
    out_ready_i = 1'b1;
    tick();
    chk("s2_rel_b", out_payload_o, word(11));
    chk("s2_rel_b_pc", PW'(out_pc_o), PW'(pc_of(11)));
    chk("s2_rel_ready", PW'(in_ready_o), 1);
    tick();
    chk("s2_rel_c", out_payload_o, word(12));
    idle();
    tick();
    chk("s2_empty", PW'(out_valid_o), 0);
    chk("s2_cnt_final", PW'(stall_cnt_o), 3);

    // 3: flush while both slots full
    out_ready_i = 1'b0;
    drv(2);
    tick();
    drv(3);
    tick();
    chk("s3_two_ready", PW'(in_ready_o), 0);
    chk("s3_isdslot", PW'(is_in_dslot_o), 1);
    idle();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("s3_valid", PW'(out_valid_o), 0);
    chk("s3_payload", out_payload_o, '0);
    chk("s3_exc", PW'(out_exc_o), 0);
    chk("s3_ready", PW'(in_ready_o), 1);
    chk("s3_isdslot0", PW'(is_in_dslot_o), 0);
    out_ready_i = 1'b1;
    tick();
    chk("s3_no_skid", PW'(out_valid_o), 0);

    // 4: accept coinciding with flush is discarded
    drv(20);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("s4_flush_valid", PW'(out_valid_o), 0);
    idle();
    tick();
    chk("s4_never", PW'(out_valid_o), 0);
    drv(21);
    tick();
    chk("s4_next", out_payload_o, word(21));
    idle();
    tick();

    // 5: asynchronous reset mid-cycle while both slots full
    out_ready_i = 1'b0;
    drv(30);
    tick();
    drv(31);
    tick();
    idle();
    chk("s5_pre_ready", PW'(in_ready_o), 0);
    #1;
    rst = 1'b0;
    #1;
    chk("s5_valid", PW'(out_valid_o), 0);
    chk("s5_ready", PW'(in_ready_o), 1);
    chk("s5_payload", out_payload_o, '0);
    chk("s5_cnt", PW'(stall_cnt_o), 0);
    #1;
    rst = 1'b1;

    // 6: stall counter saturation, untouched by flush
    drv(40);
    tick();
    idle();
    chk("s6_cnt0", PW'(stall_cnt_o), 0);
    for (int i = 0; i < 14; i++) tick();
    chk("s6_cnt14", PW'(stall_cnt_o), 14);
    tick();
    chk("s6_cnt15", PW'(stall_cnt_o), 15);
    for (int i = 0; i < 5; i++) tick();
    chk("s6_sat", PW'(stall_cnt_o), 15);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("s6_flush_cnt", PW'(stall_cnt_o), 15);
    chk("s6_flush_valid", PW'(out_valid_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
